// File: rtl/xcorr_mac_sched_if.sv
// Bundle of control, sample-buffer read, MAC operand/result and lag-result handshake signals.
// master = the sequencer, slave = the RAMs / MAC / result sink around it.
interface xcorr_mac_sched_if #(
  parameter int DW    = 16,
  parameter int AW    = 8,
  parameter int ACC_W = 48
);
  logic             start;
  logic [AW:0]      len;
  logic [AW-1:0]    max_lag;
  logic             busy;
  logic             done;
  logic             cfg_err;

  logic             rd_en;
  logic [AW-1:0]    rd_addr_x;
  logic [AW-1:0]    rd_addr_y;
  logic [DW-1:0]    x_data;
  logic [DW-1:0]    y_data;

  logic [DW-1:0]    mac_a;
  logic [DW-1:0]    mac_b;
  logic             mac_vld;
  logic             mac_first;
  logic [ACC_W-1:0] mac_p;

  logic [ACC_W-1:0] res_data;
  logic [AW-1:0]    res_lag;
  logic             res_valid;
  logic             res_ready;

  modport master (
    input  start, len, max_lag, x_data, y_data, mac_p, res_ready,
    output busy, done, cfg_err, rd_en, rd_addr_x, rd_addr_y,
           mac_a, mac_b, mac_vld, mac_first, res_data, res_lag, res_valid
  );

  modport slave (
    output start, len, max_lag, x_data, y_data, mac_p, res_ready,
    input  busy, done, cfg_err, rd_en, rd_addr_x, rd_addr_y,
           mac_a, mac_b, mac_vld, mac_first, res_data, res_lag, res_valid
  );
endinterface

// File: rtl/xcorr_mac_sched.sv
// Cross-correlation sequencer: per lag, (len-k) reads + 1 + MAC_LAT cycles to a result.
// Result held on res_valid until res_ready; the stall is unbounded and freezes all MAC traffic.
module xcorr_mac_sched #(
  parameter int DW      = 16,
  parameter int AW      = 8,
  parameter int ACC_W   = 48,
  parameter int MAC_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  xcorr_mac_sched_if.master  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam int CW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  logic [1:0]       state_q, state_d;
  logic [AW:0]      len_q, len_d;
  logic [AW-1:0]    max_lag_q, max_lag_d;
  logic [AW-1:0]    k_q, k_d;
  logic [AW-1:0]    i_q, i_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mac_vld_q, mac_vld_d;
  logic             mac_first_q, mac_first_d;
  logic [ACC_W-1:0] res_data_q, res_data_d;
  logic [AW-1:0]    res_lag_q, res_lag_d;
  logic             res_valid_q, res_valid_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             cfg_bad;
  logic [AW:0]      last_i;
  logic             fetching;
  logic [DW-1:0]    x_sel, y_sel;

  assign cfg_bad = (bus.len == '0) || ({1'b0, bus.max_lag} >= bus.len);
  // Last i of the current lag; k < len is guaranteed once a start is accepted.
  assign last_i  = len_q - {{AW{1'b0}}, 1'b1} - {1'b0, k_q};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    max_lag_d   = max_lag_q;
    k_d         = k_q;
    i_d         = i_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_lag_d   = res_lag_q;
    res_valid_d = res_valid_q;
    mac_vld_d   = 1'b0;
    mac_first_d = 1'b0;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            len_d     = bus.len;
            max_lag_d = bus.max_lag;
            k_d       = '0;
            i_d       = '0;
            state_d   = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        // Operands arrive one cycle after the read, so the MAC strobe is a delayed copy.
        mac_vld_d   = 1'b1;
        mac_first_d = (i_q == '0);
        if ({1'b0, i_q} == last_i) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          i_d = i_q + 1'b1;
        end
      end

      S_DRAIN: begin
        if (cnt_q == CW'(MAC_LAT)) begin
          res_data_d  = bus.mac_p;
          res_lag_d   = k_q;
          res_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_OUT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          if (k_q == max_lag_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            k_d     = k_q + 1'b1;
            i_d     = '0;
            state_d = S_FETCH;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      max_lag_q   <= '0;
      k_q         <= '0;
      i_q         <= '0;
      cnt_q       <= '0;
      mac_vld_q   <= 1'b0;
      mac_first_q <= 1'b0;
      res_data_q  <= '0;
      res_lag_q   <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      max_lag_q   <= max_lag_d;
      k_q         <= k_d;
      i_q         <= i_d;
      cnt_q       <= cnt_d;
      mac_vld_q   <= mac_vld_d;
      mac_first_q <= mac_first_d;
      res_data_q  <= res_data_d;
      res_lag_q   <= res_lag_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign fetching      = (state_q == S_FETCH);
  assign bus.rd_en     = fetching;
  assign bus.rd_addr_x = fetching ? i_q + k_q : '0;
  assign bus.rd_addr_y = fetching ? i_q : '0;

  // Operands pass straight from the RAM outputs; gated so idle/reset cycles show zero.
  assign x_sel         = mac_vld_q ? bus.x_data : '0;
  assign y_sel         = mac_vld_q ? bus.y_data : '0;
  assign bus.mac_a     = x_sel;
  assign bus.mac_b     = y_sel;
  assign bus.mac_vld   = mac_vld_q;
  assign bus.mac_first = mac_first_q;

  assign bus.res_data  = res_data_q;
  assign bus.res_lag   = res_lag_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_xcorr_mac_sched.sv
// Randomized bench for xcorr_mac_sched with RAM/MAC models and a queue-based reference.
module tb_xcorr_mac_sched;
  localparam int DW = 16, AW = 8, ACC_W = 48, MAC_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xcorr_mac_sched_if #(.DW(DW), .AW(AW), .ACC_W(ACC_W)) bus ();
  xcorr_mac_sched #(.DW(DW), .AW(AW), .ACC_W(ACC_W), .MAC_LAT(MAC_LAT))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int ax; int ay; } addr_t;
  typedef struct { bit first; logic [DW-1:0] a; logic [DW-1:0] b; } mac_t;
  typedef struct { int lag; logic [ACC_W-1:0] data; } res_t;

  int checks = 0, errors = 0;
  int xs[256], ys[256];
  addr_t exp_addr[$];
  mac_t  exp_mac[$];
  res_t  exp_res[$];
  res_t  got[$];
  int    lag2_x[$];
  int    rd_cnt, first_cnt, done_cnt;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Sample buffers: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.x_data <= DW'(xs[bus.rd_addr_x]);
      bus.y_data <= DW'(ys[bus.rd_addr_y]);
    end
  end

  // MAC: result of an operand pair shows on mac_p MAC_LAT cycles later.
  logic [ACC_W-1:0] pipe [MAC_LAT];
  longint acc = 0, prod;
  always @(posedge clk) begin
    if (bus.mac_vld) begin
      prod = longint'($signed(bus.mac_a)) * longint'($signed(bus.mac_b));
      acc  = bus.mac_first ? prod : acc + prod;
    end
    pipe[0] <= acc[ACC_W-1:0];
    for (int j = 1; j < MAC_LAT; j++) pipe[j] <= pipe[j-1];
  end
  assign bus.mac_p = pipe[MAC_LAT-1];

  function automatic logic [ACC_W-1:0] ref_r(int n, int k);
    longint s = 0;
    for (int i = 0; i < n - k; i++) s += longint'(xs[i+k]) * longint'(ys[i]);
    return s[ACC_W-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] got_data(int idx);
    return (got.size() > idx) ? got[idx].data : 'x;
  endfunction

  function automatic int got_lag(int idx);
    return (got.size() > idx) ? got[idx].lag : -1;
  endfunction

  task automatic clear_model();
    exp_addr.delete(); exp_mac.delete(); exp_res.delete();
  endtask

  task automatic build(int n, int ml);
    clear_model();
    for (int k = 0; k <= ml; k++) begin
      for (int i = 0; i < n - k; i++) begin
        exp_addr.push_back('{ax: i + k, ay: i});
        exp_mac.push_back('{first: (i == 0), a: DW'(xs[i+k]), b: DW'(ys[i])});
      end
      exp_res.push_back('{lag: k, data: ref_r(n, k)});
    end
  endtask

  // Per-cycle comparison of every DUT output against the reference queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_en) begin
        rd_cnt++;
        if (int'(bus.rd_addr_x) - int'(bus.rd_addr_y) == 2) lag2_x.push_back(int'(bus.rd_addr_x));
        if (exp_addr.size() == 0) check("rd_en_unexpected", bus.rd_en, 0);
        else begin
          check("rd_addr_x", bus.rd_addr_x, exp_addr[0].ax);
          check("rd_addr_y", bus.rd_addr_y, exp_addr[0].ay);
          void'(exp_addr.pop_front());
        end
      end
      if (bus.mac_vld) begin
        if (bus.mac_first) first_cnt++;
        if (exp_mac.size() == 0) check("mac_vld_unexpected", bus.mac_vld, 0);
        else begin
          check("mac_first", bus.mac_first, exp_mac[0].first);
          check("mac_a", bus.mac_a, exp_mac[0].a);
          check("mac_b", bus.mac_b, exp_mac[0].b);
          void'(exp_mac.pop_front());
        end
      end
      if (bus.res_valid) begin
        if ((bus.rd_en || bus.mac_vld)) check("mac_activity_in_out", {bus.rd_en, bus.mac_vld}, 0);
        if (exp_res.size() == 0) check("res_valid_unexpected", bus.res_valid, 0);
        else begin
          check("res_data", bus.res_data, exp_res[0].data);
          check("res_lag", bus.res_lag, exp_res[0].lag);
          if (bus.res_ready) begin
            got.push_back('{lag: int'(bus.res_lag), data: bus.res_data});
            void'(exp_res.pop_front());
          end
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic check_zero(string tag);
    check({tag, "_ctl"}, {bus.rd_en, bus.mac_vld, bus.mac_first, bus.res_valid,
                          bus.busy, bus.done, bus.cfg_err}, 0);
    check({tag, "_addr"}, {bus.rd_addr_x, bus.rd_addr_y}, 0);
    check({tag, "_mac_ab"}, {bus.mac_a, bus.mac_b}, 0);
    check({tag, "_res_data"}, bus.res_data, 0);
    check({tag, "_res_lag"}, bus.res_lag, 0);
  endtask

  // mode: 0 ready always high, 1 random ready, 2 first result stalled 10 cycles.
  task automatic run_job(int n, int ml, int mode, bit poke);
    int stall = 10;
    bit fin = 0;
    build(n, ml);
    rd_cnt = 0; first_cnt = 0; done_cnt = 0;
    got.delete(); lag2_x.delete();
    bus.len = (AW+1)'(n); bus.max_lag = AW'(ml); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 5000 && !fin; c++) begin
      if (mode == 0) bus.res_ready = 1'b1;
      else if (mode == 1) bus.res_ready = 1'($urandom_range(0, 1));
      else if (bus.res_valid && stall > 0) begin bus.res_ready = 1'b0; stall--; end
      else bus.res_ready = 1'b1;
      if (poke && c == 5 && bus.busy) begin
        bus.start = 1'b1; bus.len = 9'd1; bus.max_lag = 8'd0;
      end else bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) fin = 1;
    end
    bus.start = 1'b0; bus.res_ready = 1'b1;
    check("done_seen", fin, 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("busy_after_done", bus.busy, 0);
    check("results_left", exp_res.size(), 0);
    check("results_count", got.size(), ml + 1);
  endtask

  task automatic bad_cfg(int n, int ml);
    clear_model();
    bus.len = (AW+1)'(n); bus.max_lag = AW'(ml); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("cfg_err_pulse", bus.cfg_err, 1);
    check("cfg_busy", bus.busy, 0);
    @(posedge clk); #1;
    check("cfg_err_drop", bus.cfg_err, 0);
    repeat (3) @(posedge clk);
    #1;
    check("cfg_busy_after", bus.busy, 0);
  endtask

  task automatic fill_random(int n);
    logic signed [DW-1:0] r;
    for (int i = 0; i < n; i++) begin
      r = DW'($urandom); xs[i] = int'(r);
      r = DW'($urandom); ys[i] = int'(r);
    end
  endtask

  initial begin
    bit found;
    int n, ml;
    bus.start = 1'b0; bus.len = '0; bus.max_lag = '0; bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Auto-correlation of 1..4, with a start poked while busy.
    for (int i = 0; i < 4; i++) begin xs[i] = i + 1; ys[i] = i + 1; end
    run_job(4, 0, 0, 1);
    check("A_r0", got_data(0), 48'd30);
    check("A_lag", got_lag(0), 0);
    check("A_rd_cycles", rd_cnt, 4);
    check("A_first_cnt", first_cnt, 1);

    // Three lags with the first result stalled by back-pressure.
    for (int i = 0; i < 4; i++) begin xs[i] = i + 1; ys[i] = 1; end
    run_job(4, 2, 2, 0);
    check("B_r0", got_data(0), 48'd10);
    check("B_r1", got_data(1), 48'd9);
    check("B_r2", got_data(2), 48'd7);
    check("B_lag2", got_lag(2), 2);
    check("B_lag2_addr_n", lag2_x.size(), 2);
    check("B_lag2_addr0", (lag2_x.size() > 0) ? lag2_x[0] : -1, 2);
    check("B_lag2_addr1", (lag2_x.size() > 1) ? lag2_x[1] : -1, 3);

    // Signed extremes.
    xs[0] = -32768; xs[1] = 2; ys[0] = -32768; ys[1] = -3;
    run_job(2, 1, 1, 0);
    check("C_r0", got_data(0), 48'd1073741818);
    check("C_r1", got_data(1), 48'hFFFF_FFFF_0000);

    bad_cfg(3, 3);
    bad_cfg(0, 0);

    // Reset mid-fetch of lag 1.
    fill_random(6);
    build(6, 3);
    got.delete();
    bus.res_ready = 1'b1;
    bus.len = 9'd6; bus.max_lag = 8'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk); #1;
      if (bus.rd_en && bus.rd_addr_x == bus.rd_addr_y + 1'b1) found = 1;
    end
    check("abort_lag1_reached", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    check_zero("abort");
    repeat (4) @(posedge clk);
    #1;
    check("abort_idle", bus.busy, 0);
    run_job(5, 0, 0, 0);
    check("post_abort_r0", got_data(0), ref_r(5, 0));

    // Address boundary: full-depth buffer.
    fill_random(256);
    run_job(256, 1, 1, 0);

    for (int t = 0; t < 8; t++) begin
      n  = $urandom_range(1, 24);
      ml = $urandom_range(0, n - 1);
      fill_random(n);
      run_job(n, ml, $urandom_range(0, 2), t[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
